// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock edge meter.
// Holds the FSM state encoding and its width.
package clk_meter_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_ACQ    = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer plus registered edge detector for an async level.
// Ports: i_clk_sys/i_rst (sync, active-high), i_async in;
//        o_rise/o_fall one-cycle strobes, o_level synced level.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk_sys,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall,
    output logic o_level
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic sync_lvl;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
        prev_d = sync_lvl;
        rise_d = sync_lvl & ~prev_q;
        fall_d = ~sync_lvl & prev_q;
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_level = sync_lvl;

endmodule

// File: rtl/clk_edge_meter.sv
// Measures period of a slow async clock, detects lock and loss of input.
// Ports: i_clk_sys, i_rst (sync, active-high), i_clk_in async input;
//        o_rise/o_fall strobes, o_period/o_period_vld, o_locked,
//        o_timeout (sticky until next rise), o_high_time.
// Optional duty measurement: define CLK_EDGE_METER_DUTY_EN.
module clk_edge_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TOL         = 1
) (
    input  logic                 i_clk_sys,
    input  logic                 i_rst,
    input  logic                 i_clk_in,
    output logic                 o_rise,
    output logic                 o_fall,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic                 o_period_vld,
    output logic                 o_locked,
    output logic                 o_timeout,
    output logic [CNT_WIDTH-1:0] o_high_time
);

    localparam int MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0] ONES   = '1;
    localparam logic [CNT_WIDTH:0]   TOL_V  = (CNT_WIDTH+1)'(TOL);
    localparam logic [MW-1:0]        LOCK_M = MW'(LOCK_COUNT);

    logic rise, fall, level;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk_sys(i_clk_sys),
        .i_rst    (i_rst),
        .i_async  (i_clk_in),
        .o_rise   (rise),
        .o_fall   (fall),
        .o_level  (level)
    );

    state_t state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] last_q, last_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [MW-1:0]        match_q, match_d;
    logic                 vld_q, vld_d;
    logic                 locked_q, locked_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH:0]   abs_diff;
    logic [MW-1:0]        match_inc;
    logic                 is_match;

    // Extra bit keeps the difference from wrapping.
    always_comb begin
        if (cnt_q >= last_q) begin
            abs_diff = {1'b0, cnt_q} - {1'b0, last_q};
        end else begin
            abs_diff = {1'b0, last_q} - {1'b0, cnt_q};
        end
        is_match  = (abs_diff <= TOL_V);
        match_inc = match_q + 1'b1;
    end

    always_comb begin
        cnt_d     = (cnt_q == ONES) ? cnt_q : cnt_q + 1'b1;
        state_d   = state_q;
        last_d    = last_q;
        period_d  = period_q;
        match_d   = match_q;
        vld_d     = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        if (rise) begin
            // A rise on the saturating cycle still counts as a rise.
            cnt_d     = CNT_WIDTH'(1);
            timeout_d = 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_FIRST;
                end
                S_FIRST: begin
                    period_d = cnt_q;
                    vld_d    = 1'b1;
                    last_d   = cnt_q;
                    match_d  = '0;
                    state_d  = S_ACQ;
                end
                S_ACQ: begin
                    period_d = cnt_q;
                    vld_d    = 1'b1;
                    last_d   = cnt_q;
                    if (is_match) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_M) begin
                            state_d  = S_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                S_LOCKED: begin
                    period_d = cnt_q;
                    vld_d    = 1'b1;
                    last_d   = cnt_q;
                    if (!is_match) begin
                        state_d  = S_ACQ;
                        locked_d = 1'b0;
                        match_d  = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (cnt_q == ONES && state_q != S_IDLE) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
            state_d   = S_IDLE;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            last_q    <= '0;
            period_q  <= '0;
            match_q   <= '0;
            vld_q     <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            period_q  <= period_d;
            match_q   <= match_d;
            vld_q     <= vld_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef CLK_EDGE_METER_DUTY_EN
    logic [CNT_WIDTH-1:0] hi_q, hi_d;
    logic [CNT_WIDTH-1:0] high_q, high_d;
    logic                 armed_q, armed_d;
    logic                 to_idle;

    assign to_idle = (state_d == S_IDLE) && (state_q != S_IDLE);

    always_comb begin
        hi_d    = (hi_q == ONES) ? hi_q : hi_q + 1'b1;
        high_d  = high_q;
        armed_d = armed_q;
        if (rise) begin
            hi_d    = CNT_WIDTH'(1);
            armed_d = 1'b1;
        end else if (to_idle) begin
            armed_d = 1'b0;
        end
        // A fall without a preceding rise has no valid start point.
        if (fall && armed_q) begin
            high_d = hi_q;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            hi_q    <= '0;
            high_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            high_q  <= high_d;
            armed_q <= armed_d;
        end
    end

    assign o_high_time = high_q;
`else
    assign o_high_time = '0;
`endif

    assign o_rise       = rise;
    assign o_fall       = fall;
    assign o_period     = period_q;
    assign o_period_vld = vld_q;
    assign o_locked     = locked_q;
    assign o_timeout    = timeout_q & ~level | timeout_q & level;

endmodule

// File: tb/tb_clk_edge_meter.sv
// Directed testbench for clk_edge_meter.
// Table of input periods with hand-computed results plus corner sequences.
module tb_clk_edge_meter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         clk_in;
    logic         o_rise;
    logic         o_fall;
    logic [W-1:0] o_period;
    logic         o_period_vld;
    logic         o_locked;
    logic         o_timeout;
    logic [W-1:0] o_high_time;

    int tests;
    int errors;

`ifdef CLK_EDGE_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    clk_edge_meter #(
        .CNT_WIDTH  (W),
        .SYNC_STAGES(2),
        .LOCK_COUNT (4),
        .TOL        (1)
    ) dut (
        .i_clk_sys   (clk),
        .i_rst       (rst),
        .i_clk_in    (clk_in),
        .o_rise      (o_rise),
        .o_fall      (o_fall),
        .o_period    (o_period),
        .o_period_vld(o_period_vld),
        .o_locked    (o_locked),
        .o_timeout   (o_timeout),
        .o_high_time (o_high_time)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int period;
        int vld;
        int locked;
        int timeout;
        int high;
    } samp_t;

    typedef struct {
        int hi;
        int lo;
        int exp_period;
        int exp_vld;
        int exp_locked;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one input cycle: high for hi cycles, low for lo cycles.
    // Samples outputs the cycle after the rise and after the fall strobe.
    task automatic run_period(input int hi, input int lo, output samp_t s);
        int n;
        bit seen;
        clk_in = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            step();
            n++;
            seen = o_rise;
        end
        chk("rise_latency", n, 3);
        step();
        n++;
        s.period  = int'(o_period);
        s.vld     = int'(o_period_vld);
        s.locked  = int'(o_locked);
        s.timeout = int'(o_timeout);
        step();
        n++;
        chk("rise_strobe_width", int'({o_rise, o_period_vld}), 0);
        while (n < hi) begin
            step();
            n++;
        end
        clk_in = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 8) begin
            step();
            n++;
            seen = o_fall;
        end
        chk("fall_latency", n, 3);
        step();
        n++;
        s.high = int'(o_high_time);
        step();
        n++;
        chk("fall_strobe_width", int'(o_fall), 0);
        while (n < lo) begin
            step();
            n++;
        end
    endtask

    vec_t  vecs[16];
    samp_t s;

    initial begin
        int w;
        bit seen;
        tests  = 0;
        errors = 0;

        vecs[0]  = '{16, 16,  0, 0, 0};
        vecs[1]  = '{16, 16, 32, 1, 0};
        vecs[2]  = '{16, 16, 32, 1, 0};
        vecs[3]  = '{16, 16, 32, 1, 0};
        vecs[4]  = '{16, 16, 32, 1, 0};
        vecs[5]  = '{17, 16, 32, 1, 1};
        vecs[6]  = '{16, 16, 33, 1, 1};
        vecs[7]  = '{16, 15, 32, 1, 1};
        vecs[8]  = '{16, 16, 31, 1, 1};
        vecs[9]  = '{20, 20, 32, 1, 1};
        vecs[10] = '{16, 16, 40, 1, 0};
        vecs[11] = '{16, 16, 32, 1, 0};
        vecs[12] = '{16, 16, 32, 1, 0};
        vecs[13] = '{16, 16, 32, 1, 0};
        vecs[14] = '{16, 16, 32, 1, 0};
        vecs[15] = '{10, 22, 32, 1, 1};

        // Reset with the input toggling.
        rst = 1'b1;
        clk_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clk_in = i[1];
            step();
            chk("reset_outputs",
                int'({o_rise, o_fall, o_period, o_period_vld,
                      o_locked, o_timeout, o_high_time}), 0);
        end
        clk_in = 1'b0;
        rst = 1'b0;
        step();
        chk("post_reset_outputs",
            int'({o_rise, o_fall, o_period, o_period_vld,
                  o_locked, o_timeout, o_high_time}), 0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | o_rise | o_fall;
        end
        chk("no_spurious_strobe", int'(seen), 0);

        // Lock acquisition, jitter tolerance, unlock and relock.
        for (int i = 0; i < 16; i++) begin
            run_period(vecs[i].hi, vecs[i].lo, s);
            chk($sformatf("v%0d_period", i), s.period, vecs[i].exp_period);
            chk($sformatf("v%0d_vld", i), s.vld, vecs[i].exp_vld);
            chk($sformatf("v%0d_locked", i), s.locked, vecs[i].exp_locked);
            chk($sformatf("v%0d_timeout", i), s.timeout, 0);
            chk($sformatf("v%0d_high", i), s.high,
                DUTY ? vecs[i].hi : 0);
        end

        // Loss of input: last rise then held low.
        run_period(16, 16, s);
        chk("pre_to_locked", s.locked, 1);
        w = 0;
        while (!o_timeout && w < 400) begin
            step();
            w++;
        end
        chk("timeout_delay", w, 227);
        chk("timeout_locked", int'(o_locked), 0);
        chk("timeout_period_hold", int'(o_period), 32);
        repeat (20) step();
        chk("timeout_sticky", int'(o_timeout), 1);

        run_period(16, 16, s);
        chk("to_clear_timeout", s.timeout, 0);
        chk("to_clear_vld", s.vld, 0);
        chk("to_clear_locked", s.locked, 0);
        run_period(16, 16, s);
        chk("first_after_to_vld", s.vld, 1);
        chk("first_after_to_period", s.period, 32);
        for (int i = 0; i < 4; i++) run_period(16, 16, s);
        chk("relock_after_to", s.locked, 1);

        // Rise exactly on the saturating count.
        run_period(16, 239, s);
        chk("sat_pre_locked", s.locked, 1);
        run_period(16, 16, s);
        chk("sat_period", s.period, 255);
        chk("sat_vld", s.vld, 1);
        chk("sat_timeout", s.timeout, 0);
        chk("sat_unlock", s.locked, 0);
        for (int i = 0; i < 4; i++) run_period(16, 16, s);
        chk("relock_not_yet", s.locked, 0);
        run_period(16, 16, s);
        chk("relock_after_sat", s.locked, 1);

        // One-cycle reset while locked.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_locked", int'(o_locked), 0);
        chk("rst_period", int'(o_period), 0);
        chk("rst_timeout", int'(o_timeout), 0);
        chk("rst_vld", int'(o_period_vld), 0);
        chk("rst_high", int'(o_high_time), 0);
        run_period(16, 16, s);
        chk("post_rst_vld", s.vld, 0);
        chk("post_rst_period", s.period, 0);
        chk("post_rst_locked", s.locked, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
